// File: rtl/pc_unit_if.sv
// Bus bundle for pc_unit: decode controls, branch-compare flag, operands,
// stall, and the instruction-memory request/acknowledge handshake.
// master = pc_unit side, slave = surrounding core / instruction memory.
interface pc_unit_if;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        stall;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        trap;
    logic [31:0] trap_pc;

    modport master (
        input  branch, jal, jalr, zero, imm, rs1_val, stall, imem_ack,
        output imem_req, pc, pc_plus4, instr_valid, trap, trap_pc
    );

    modport slave (
        output branch, jal, jalr, zero, imm, rs1_val, stall, imem_ack,
        input  imem_req, pc, pc_plus4, instr_valid, trap, trap_pc
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter and next-PC sequencer for the single-cycle core.
// BOOT -> FETCH (request until ack) -> EXEC (commit, pick next PC) -> FETCH,
// with a one-cycle TRAP detour for misaligned control-flow targets.
// Optional feature: define PC_RETIRE_CNT_EN to add the retire_cnt output.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.master   bus
`ifdef PC_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        EXEC,
        TRAP
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [31:0] pcReg;
    logic [31:0] pcNext;
    logic [31:0] trapPcReg;
    logic [31:0] trapPcNext;
    logic [31:0] seqTarget;
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        imemReq;
    logic        instrValid;
    logic        trapPulse;

    assign seqTarget = pcReg + 32'd4;

    // Target selection: jalr > jal > taken branch > sequential.
    always_comb begin
        target   = seqTarget;
        redirect = 1'b0;
        if (bus.jalr) begin
            target   = (bus.rs1_val + bus.imm) & ~32'h1;
            redirect = 1'b1;
        end else if (bus.jal || (bus.branch && bus.zero)) begin
            target   = pcReg + bus.imm;
            redirect = 1'b1;
        end
    end

    // Only redirected targets can be misaligned; fall-through is always aligned.
    assign misaligned = redirect && target[1];

    // State, PC and trap-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pcReg     <= RESET_VEC;
            trapPcReg <= '0;
        end else begin
            state     <= nextState;
            pcReg     <= pcNext;
            trapPcReg <= trapPcNext;
        end
    end

    // Next-state, next-PC and per-state strobes.
    always_comb begin
        nextState  = state;
        pcNext     = pcReg;
        trapPcNext = trapPcReg;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        trapPulse  = 1'b0;
        case (state)
            BOOT: begin
                nextState = FETCH;
            end
            FETCH: begin
                imemReq = 1'b1;
                if (bus.imem_ack) begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                instrValid = 1'b1;
                if (!bus.stall) begin
                    if (misaligned) begin
                        trapPcNext = target;
                        nextState  = TRAP;
                    end else begin
                        pcNext    = target;
                        nextState = FETCH;
                    end
                end
            end
            TRAP: begin
                trapPulse = 1'b1;
                pcNext    = TRAP_VEC;
                nextState = FETCH;
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

    assign bus.imem_req    = imemReq;
    assign bus.instr_valid = instrValid;
    assign bus.trap        = trapPulse;
    assign bus.pc          = pcReg;
    assign bus.pc_plus4    = seqTarget;
    assign bus.trap_pc     = trapPcReg;

`ifdef PC_RETIRE_CNT_EN
    logic        retireNow;
    logic [31:0] retireCnt;

    assign retireNow = (state == EXEC) && !bus.stall && !misaligned;

    // Count committed instructions; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            retireCnt <= '0;
        end else if (retireNow) begin
            retireCnt <= retireCnt + 32'd1;
        end
    end

    assign retire_cnt = retireCnt;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and next-PC sequencer for the single-cycle core. It sits directly downstream of the branch comparison unit and consumes its `zero` flag, together with decode jump controls and the immediate, to select the next fetch address. It also drives a request/acknowledge handshake to instruction memory, presents a qualified-instruction strobe to the datapath, and traps on misaligned control-flow targets.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset
- `TRAP_VEC`, 32'h0000_0100, PC value loaded on a misaligned-target trap

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `branch`  in  1  decode: conditional branch instruction
- `jal`  in  1  decode: JAL
- `jalr`  in  1  decode: JALR
- `zero`  in  1  comparison result from the branch compare stage; 1 = branch condition true
- `imm`  in  32  sign-extended immediate from decode
- `rs1_val`  in  32  register-file rs1 operand (JALR base)
- `stall`  in  1  datapath hold request; freezes the EXEC state
- `imem_ack`  in  1  instruction memory: instruction word valid for `pc`
- `imem_req`  out  1  instruction memory: fetch request for `pc`
- `pc`  out  32  current PC (registered)
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32 (combinational from `pc`; link value for JAL/JALR)
- `instr_valid`  out  1  instruction at `pc` is valid; datapath may commit
- `trap`  out  1  one-cycle misaligned-target trap pulse
- `trap_pc`  out  32  offending target address, held until the next trap or reset

## Operation
- FSM states: BOOT, FETCH, EXEC, TRAP.
- BOOT: `imem_req`=0 and `instr_valid`=0. Go to FETCH on the next cycle.
- FETCH: `imem_req`=1 and `pc` is stable. `imem_ack` is sampled only in this state; it may assert in the first FETCH cycle. On `imem_ack`, go to EXEC.
- EXEC: `instr_valid`=1.
  - If `stall`=1: stay in EXEC, hold `pc`, and ignore the control inputs.
  - Otherwise, compute the target with this priority: `jalr` > `jal` > (`branch` & `zero`) > sequential.
  - JALR target = (`rs1_val` + `imm`) & ~32'h1.
  - JAL or taken-branch target = `pc` + `imm`.
  - Sequential target = `pc_plus4`.
  - All additions wrap modulo 2^32.
  - If the target is non-sequential and target[1]=1: go to TRAP, latch `trap_pc` <= target, and leave `pc` unchanged.
  - Otherwise: `pc` <= target and go to FETCH.
- TRAP: `trap`=1 for exactly this cycle, `pc` <= `TRAP_VEC`, then go to FETCH.
- Decode conflicts:
  - `jal` and `jalr` both set: JALR wins.
  - `branch` with `zero`=0 and no jump: sequential.
- Not-taken branches never trap, whatever `imm` is.

## Timing
- Reset values: `pc`=`RESET_VEC`, state=BOOT, `imem_req`=0, `instr_valid`=0, `trap`=0, `trap_pc`=0; retire counter = 0 when enabled.
- `rst` overrides every state and input on the same edge, including mid-FETCH, mid-stall and in TRAP.
- Minimum throughput is 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- `pc` changes only on the edge that leaves EXEC (non-trap) or leaves TRAP.
- `instr_valid` and `imem_req` are never high in the same cycle.
- Reset to first `imem_req`: 1 cycle (BOOT).

## Configuration
- Macro: `PC_RETIRE_CNT_EN`.
- When defined:
  - Adds output port `retire_cnt` (out, 32): count of instructions retired.
  - Increments on every non-stalled EXEC exit that does not go to TRAP.
  - Wraps from 32'hFFFF_FFFF to 0; reset value is 0.
- When undefined: the port and the counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset then sequential flow: release `rst`, ack every FETCH -> 1 BOOT cycle, `pc` = 0x0, 0x4, 0x8, one `instr_valid` pulse per 2 cycles.
- Taken branch and not-taken branch:
  - At `pc`=0x10 with `branch`=1, `zero`=1, `imm`=-8 -> `pc`=0x08.
  - Same with `zero`=0 -> `pc`=0x14.
- JALR priority and bit-0 clear: `jal`=1, `jalr`=1, `rs1_val`=0x2001, `imm`=0x4 -> `pc`=0x2004 and `pc_plus4` before the update equals old `pc`+4.
- Misaligned trap: JAL at `pc`=0x20 with `imm`=0x6 -> `trap` high for 1 cycle, `trap_pc`=0x26, then `pc`=0x100, FETCH, and `retire_cnt` unchanged.
- Stall and delayed ack:
  - `imem_ack` held low 3 cycles -> `imem_req` stays high and `pc` is stable.
  - `stall`=1 for 4 EXEC cycles with `jal` toggling -> `pc` is held, and the redirect happens only on the first unstalled cycle.
- Wrap and mid-operation reset:
  - `pc`=0xFFFF_FFFC sequential -> `pc`=0x0.
  - Assert `rst` during a stall -> next cycle `pc`=`RESET_VEC`, state BOOT, all outputs at reset values.
